// File: rtl/unidad_acceso_memoria_if.sv
// Buses for the memory access unit: the CPU request/response side and the
// data-memory strobe side.
interface unidad_acceso_memoria_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_escr;
    logic [1:0]  req_tam;
    logic        req_sign;
    logic [31:0] req_direc;
    logic [31:0] req_dato;
    logic        resp_valid;
    logic [31:0] resp_dato;
    logic        err_alin;

    modport master (
        output req_valid, req_escr, req_tam, req_sign, req_direc, req_dato,
        input  req_ready, resp_valid, resp_dato, err_alin
    );

    modport slave (
        input  req_valid, req_escr, req_tam, req_sign, req_direc, req_dato,
        output req_ready, resp_valid, resp_dato, err_alin
    );
endinterface

interface memoria_datos_if;
    logic        EscrMem;
    logic        LeerMem;
    logic [31:0] Direc;
    logic [31:0] Datain;
    logic [31:0] Dataout;

    modport master (
        output EscrMem, LeerMem, Direc, Datain,
        input  Dataout
    );

    modport slave (
        input  EscrMem, LeerMem, Direc, Datain,
        output Dataout
    );
endinterface

// File: rtl/unidad_acceso_memoria.sv
// Load/store initiator for the data memory: sub-word loads with extension and
// sub-word stores as read-modify-write.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// LECT  | LeerMem held for LAT_LECT+1 cycles, Dataout captured on exit
// MODIF | write back the read word with the target lane replaced
// ESCR  | single-cycle word write
// RESP  | one-cycle resp_valid pulse
// ERR   | misaligned request answered, no memory access
module unidad_acceso_memoria #(
    parameter int unsigned LAT_LECT      = 1,
    parameter bit          CHEQUEAR_ALIN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    unidad_acceso_memoria_if.slave cpu,
    memoria_datos_if.master        mem
);
    typedef enum logic [2:0] {IDLE, LECT, MODIF, ESCR, RESP, ERR} estado_t;

    localparam logic [3:0] CNT_INI = 4'(LAT_LECT);

    estado_t     estado, estado_sig;

    logic        escr_q, sign_q;
    logic [1:0]  tam_q;
    logic [31:0] direc_q, dato_q;
    logic [3:0]  cnt_q, cnt_sig;

    logic        escr_mem_q, leer_mem_q, resp_valid_q, err_alin_q;
    logic [31:0] direc_mem_q, datain_q, resp_dato_q;
    logic [31:0] direc_mem_sig, datain_sig, resp_dato_sig;

    logic        aceptar, es_half_in, es_word_in, desalin_in;
    logic [31:0] direc_in, direc_sel;

    function automatic logic [31:0] extraer(input logic [31:0] w, input logic [1:0] tam,
                                            input logic sgn, input logic [1:0] a);
        logic [31:0] s;
        logic [31:0] r;
        case (tam)
            2'b00: begin
                s = w >> {a, 3'b000};
                r = sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            end
            2'b01: begin
                s = w >> {a[1], 4'b0000};
                r = sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fusionar(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] tam, input logic [1:0] a);
        logic [31:0] mascara;
        logic [31:0] ins;
        if (tam == 2'b00) begin
            mascara = 32'h0000_00FF << {a, 3'b000};
            ins     = {24'h0, d[7:0]} << {a, 3'b000};
        end else begin
            mascara = 32'h0000_FFFF << {a[1], 4'b0000};
            ins     = {16'h0, d[15:0]} << {a[1], 4'b0000};
        end
        return (w & ~mascara) | (ins & mascara);
    endfunction

    assign cpu.req_ready  = (estado == IDLE) && rst_n;
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.resp_dato  = resp_dato_q;
    assign cpu.err_alin   = err_alin_q;
    assign mem.EscrMem    = escr_mem_q;
    assign mem.LeerMem    = leer_mem_q;
    assign mem.Direc      = direc_mem_q;
    assign mem.Datain     = datain_q;

    assign aceptar    = cpu.req_valid && cpu.req_ready;
    assign es_half_in = (cpu.req_tam == 2'b01);
    assign es_word_in = cpu.req_tam[1];

    // With checking disabled the offending low address bits are simply dropped.
    always_comb begin
        direc_in   = cpu.req_direc;
        desalin_in = 1'b0;
        if (CHEQUEAR_ALIN) begin
            desalin_in = (es_half_in && cpu.req_direc[0]) ||
                         (es_word_in && (cpu.req_direc[1:0] != 2'b00));
        end else if (es_half_in) begin
            direc_in[0] = 1'b0;
        end else if (es_word_in) begin
            direc_in[1:0] = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig    = estado;
        cnt_sig       = cnt_q;
        direc_mem_sig = '0;
        datain_sig    = '0;
        resp_dato_sig = resp_dato_q;
        direc_sel     = (estado == IDLE) ? direc_in : direc_q;

        case (estado)
            IDLE: begin
                if (aceptar) begin
                    if (desalin_in) begin
                        estado_sig = ERR;
                    end else if (cpu.req_escr && es_word_in) begin
                        estado_sig = ESCR;
                    end else begin
                        estado_sig = LECT;
                        cnt_sig    = CNT_INI;
                    end
                end
            end
            LECT: begin
                if (cnt_q == 4'd0) begin
                    estado_sig = escr_q ? MODIF : RESP;
                end else begin
                    cnt_sig = cnt_q - 4'd1;
                end
            end
            MODIF, ESCR: estado_sig = RESP;
            RESP, ERR:   estado_sig = IDLE;
            default:     estado_sig = IDLE;
        endcase

        // Outputs are registered from the next state so strobes change only on the edge.
        if (estado_sig inside {LECT, MODIF, ESCR}) begin
            direc_mem_sig = {direc_sel[31:2], 2'b00};
        end
        if (estado_sig == ESCR) begin
            datain_sig = cpu.req_dato;
        end else if (estado_sig == MODIF) begin
            datain_sig = fusionar(mem.Dataout, dato_q, tam_q, direc_q[1:0]);
        end
        if (estado_sig == RESP) begin
            resp_dato_sig = (estado == LECT) ? extraer(mem.Dataout, tam_q, sign_q, direc_q[1:0])
                                             : '0;
        end else if (estado_sig == ERR) begin
            resp_dato_sig = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            escr_q       <= 1'b0;
            tam_q        <= '0;
            sign_q       <= 1'b0;
            direc_q      <= '0;
            dato_q       <= '0;
            escr_mem_q   <= 1'b0;
            leer_mem_q   <= 1'b0;
            direc_mem_q  <= '0;
            datain_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_dato_q  <= '0;
            err_alin_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_sig;
            escr_mem_q   <= (estado_sig == ESCR) || (estado_sig == MODIF);
            leer_mem_q   <= (estado_sig == LECT);
            direc_mem_q  <= direc_mem_sig;
            datain_q     <= datain_sig;
            resp_valid_q <= (estado_sig == RESP) || (estado_sig == ERR);
            err_alin_q   <= (estado_sig == ERR);
            resp_dato_q  <= resp_dato_sig;
            if (aceptar) begin
                escr_q  <= cpu.req_escr;
                tam_q   <= cpu.req_tam;
                sign_q  <= cpu.req_sign;
                direc_q <= direc_in;
                dato_q  <= cpu.req_dato;
            end
        end
    end
endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Directed bench for unidad_acceso_memoria with a registered one-edge data memory model.
module tb_unidad_acceso_memoria;
    logic clk;
    logic rst_n;

    unidad_acceso_memoria_if cpu_b ();
    memoria_datos_if         mem_b ();

    unidad_acceso_memoria #(
        .LAT_LECT      (1),
        .CHEQUEAR_ALIN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_b),
        .mem   (mem_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] memoria [64];

    always @(posedge clk) begin
        if (mem_b.EscrMem) memoria[mem_b.Direc[7:2]] = mem_b.Datain;
        if (mem_b.LeerMem) mem_b.Dataout <= memoria[mem_b.Direc[7:2]];
    end

    int total = 0;
    int bad   = 0;
    int solapes = 0;
    int ociosos = 0;

    int          c_resp, n_leer, n_escr, p_escr, fantasma;
    logic [31:0] d_resp, din_e, dir_a, d_after;
    logic        e_resp, v_after, rdy_after;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, esp);
        end
    endtask

    task automatic tx(input logic escr, input logic [1:0] tam, input logic sgn,
                      input logic [31:0] dir, input logic [31:0] dato);
        @(negedge clk);
        comprobar("ready_pre", 32'(cpu_b.req_ready), 32'd1);
        cpu_b.req_valid = 1'b1;
        cpu_b.req_escr  = escr;
        cpu_b.req_tam   = tam;
        cpu_b.req_sign  = sgn;
        cpu_b.req_direc = dir;
        cpu_b.req_dato  = dato;
        @(posedge clk);
        #1;
        cpu_b.req_valid = 1'b0;
        cpu_b.req_escr  = ~escr;
        cpu_b.req_tam   = ~tam;
        cpu_b.req_sign  = ~sgn;
        cpu_b.req_direc = 32'h5A5A_5A5A;
        cpu_b.req_dato  = 32'hA5A5_A5A5;
        c_resp = -1; n_leer = 0; n_escr = 0; p_escr = -1;
        din_e = '0; dir_a = '0; d_resp = '0; e_resp = 1'b0;
        for (int c = 1; c <= 40 && c_resp < 0; c++) begin
            @(negedge clk);
            if (mem_b.LeerMem) begin
                n_leer++;
                dir_a = mem_b.Direc;
            end
            if (mem_b.EscrMem) begin
                n_escr++;
                din_e = mem_b.Datain;
                dir_a = mem_b.Direc;
                if (p_escr < 0) p_escr = c;
            end
            if (mem_b.LeerMem && mem_b.EscrMem) solapes++;
            if (!mem_b.EscrMem && mem_b.Datain != 32'h0) ociosos++;
            if (!mem_b.LeerMem && !mem_b.EscrMem && mem_b.Direc != 32'h0) ociosos++;
            if (cpu_b.resp_valid) begin
                c_resp = c;
                d_resp = cpu_b.resp_dato;
                e_resp = cpu_b.err_alin;
            end
        end
        @(negedge clk);
        v_after   = cpu_b.resp_valid;
        rdy_after = cpu_b.req_ready;
        d_after   = cpu_b.resp_dato;
    endtask

    typedef struct {
        logic [1:0]  tam;
        logic        sgn;
        logic [31:0] dir;
        logic [31:0] esp;
    } vec_carga_t;

    vec_carga_t cargas [7];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cpu_b.req_valid = 1'b0;
        cpu_b.req_escr  = 1'b0;
        cpu_b.req_tam   = 2'b00;
        cpu_b.req_sign  = 1'b0;
        cpu_b.req_direc = '0;
        cpu_b.req_dato  = '0;
        for (int i = 0; i < 64; i++) memoria[i] = 32'h0;
        memoria[1] = 32'h8000_00F0;
        memoria[0] = 32'h1122_3344;

        cargas[0] = '{2'b00, 1'b1, 32'hFFFF_FF13, 32'hFFFF_FF80};
        cargas[1] = '{2'b00, 1'b0, 32'hFFFF_FF13, 32'h0000_0080};
        cargas[2] = '{2'b01, 1'b1, 32'hFFFF_FF10, 32'h0000_7F01};
        cargas[3] = '{2'b01, 1'b1, 32'hFFFF_FF12, 32'hFFFF_80FF};
        cargas[4] = '{2'b01, 1'b0, 32'hFFFF_FF12, 32'h0000_80FF};
        cargas[5] = '{2'b00, 1'b0, 32'hFFFF_FF11, 32'h0000_007F};
        cargas[6] = '{2'b11, 1'b1, 32'hFFFF_FF10, 32'h80FF_7F01};

        repeat (3) @(negedge clk);
        comprobar("ready_in_reset", 32'(cpu_b.req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        comprobar("idle_ready", 32'(cpu_b.req_ready), 32'd1);
        comprobar("idle_strobes", 32'({mem_b.EscrMem, mem_b.LeerMem}), 32'd0);
        comprobar("idle_direc", mem_b.Direc, 32'h0);
        comprobar("idle_datain", mem_b.Datain, 32'h0);
        comprobar("idle_resp", 32'({cpu_b.resp_valid, cpu_b.err_alin}), 32'd0);
        comprobar("idle_resp_dato", cpu_b.resp_dato, 32'h0);

        // word store
        tx(1'b1, 2'b10, 1'b0, 32'hFFFF_FF10, 32'hDEAD_BEEF);
        comprobar("ws_resp_cycle", 32'(c_resp), 32'd2);
        comprobar("ws_escr_cycle", 32'(p_escr), 32'd1);
        comprobar("ws_n_escr", 32'(n_escr), 32'd1);
        comprobar("ws_n_leer", 32'(n_leer), 32'd0);
        comprobar("ws_datain", din_e, 32'hDEAD_BEEF);
        comprobar("ws_direc", dir_a, 32'hFFFF_FF10);
        comprobar("ws_err", 32'(e_resp), 32'd0);
        comprobar("ws_resp_dato", d_resp, 32'h0);
        comprobar("ws_pulse", 32'(v_after), 32'd0);
        comprobar("ws_ready_after", 32'(rdy_after), 32'd1);

        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FF10, 32'h0);
        comprobar("ws_readback", d_resp, 32'hDEAD_BEEF);
        comprobar("wl_held", d_after, 32'hDEAD_BEEF);

        // word load, LAT_LECT=1
        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FE04, 32'h0);
        comprobar("wl_resp_cycle", 32'(c_resp), 32'd3);
        comprobar("wl_n_leer", 32'(n_leer), 32'd2);
        comprobar("wl_n_escr", 32'(n_escr), 32'd0);
        comprobar("wl_direc", dir_a, 32'hFFFF_FE04);
        comprobar("wl_dato", d_resp, 32'h8000_00F0);
        comprobar("wl_err", 32'(e_resp), 32'd0);

        // sub-word loads
        memoria[4] = 32'h80FF_7F01;
        for (int i = 0; i < 7; i++) begin
            tx(1'b0, cargas[i].tam, cargas[i].sgn, cargas[i].dir, 32'h0);
            comprobar($sformatf("load_%0d_dato", i), d_resp, cargas[i].esp);
            comprobar($sformatf("load_%0d_cycle", i), 32'(c_resp), 32'd3);
        end

        // byte store read-modify-write
        tx(1'b1, 2'b00, 1'b0, 32'hFFFF_FE02, 32'h0000_00AB);
        comprobar("bs_resp_cycle", 32'(c_resp), 32'd4);
        comprobar("bs_n_leer", 32'(n_leer), 32'd2);
        comprobar("bs_n_escr", 32'(n_escr), 32'd1);
        comprobar("bs_escr_cycle", 32'(p_escr), 32'd3);
        comprobar("bs_datain", din_e, 32'h11AB_3344);
        comprobar("bs_direc", dir_a, 32'hFFFF_FE00);
        comprobar("bs_resp_dato", d_resp, 32'h0);
        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FE00, 32'h0);
        comprobar("bs_readback", d_resp, 32'h11AB_3344);

        tx(1'b1, 2'b01, 1'b0, 32'hFFFF_FE02, 32'h1234_BEEF);
        comprobar("hs_datain", din_e, 32'hBEEF_3344);
        tx(1'b1, 2'b00, 1'b0, 32'hFFFF_FE00, 32'hFFFF_FFCD);
        comprobar("bs0_datain", din_e, 32'hBEEF_33CD);
        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FE00, 32'h0);
        comprobar("sub_readback", d_resp, 32'hBEEF_33CD);

        // misaligned requests
        tx(1'b0, 2'b01, 1'b1, 32'hFFFF_FF01, 32'h0);
        comprobar("mis_h_cycle", 32'(c_resp), 32'd1);
        comprobar("mis_h_err", 32'(e_resp), 32'd1);
        comprobar("mis_h_dato", d_resp, 32'h0);
        comprobar("mis_h_strobes", 32'(n_leer + n_escr), 32'd0);
        comprobar("mis_h_err_pulse", 32'(v_after), 32'd0);
        tx(1'b1, 2'b10, 1'b0, 32'hFFFF_FF12, 32'hCAFE_F00D);
        comprobar("mis_w_err", 32'(e_resp), 32'd1);
        comprobar("mis_w_strobes", 32'(n_leer + n_escr), 32'd0);
        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FF10, 32'h0);
        comprobar("mis_w_untouched", d_resp, 32'h80FF_7F01);
        comprobar("ok_err_clear", 32'(e_resp), 32'd0);

        // reset in the middle of a read
        @(negedge clk);
        cpu_b.req_valid = 1'b1;
        cpu_b.req_escr  = 1'b0;
        cpu_b.req_tam   = 2'b10;
        cpu_b.req_direc = 32'hFFFF_FE04;
        @(posedge clk);
        #1;
        cpu_b.req_valid = 1'b0;
        @(negedge clk);
        comprobar("rst_leer_pre", 32'(mem_b.LeerMem), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        comprobar("rst_leer_drop", 32'(mem_b.LeerMem), 32'd0);
        comprobar("rst_direc_drop", mem_b.Direc, 32'h0);
        comprobar("rst_ready_low", 32'(cpu_b.req_ready), 32'd0);
        fantasma = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_b.resp_valid || mem_b.LeerMem || mem_b.EscrMem) fantasma++;
        end
        rst_n = 1'b1;
        #1;
        comprobar("rst_ready_post", 32'(cpu_b.req_ready), 32'd1);
        comprobar("rst_no_resp", 32'(fantasma), 32'd0);
        tx(1'b0, 2'b10, 1'b0, 32'hFFFF_FE04, 32'h0);
        comprobar("rst_wl_cycle", 32'(c_resp), 32'd3);
        comprobar("rst_wl_dato", d_resp, 32'h8000_00F0);

        comprobar("no_overlap", 32'(solapes), 32'd0);
        comprobar("idle_bus_zero", 32'(ociosos), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
